pc_sequencer: RTL and testbench

//  Program-counter source for the single-cycle MIPS core (main). Drives the core's pc input.

---
 rtl/pc_seq_pkg.sv | 22 ++
 rtl/sat_counter.sv | 29 ++
 rtl/pc_sequencer.sv | 134 +++++++++++++
 tb/tb_pc_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types, defaults and helpers for the program-counter sequencer.
//   pc_seq_state_e : sequencer FSM states (idle, running, halted)
//   PC_STEP_DEF    : default pc increment in bytes
//   HALT_PC_DEF    : default halt address (end of the 3x3 matrix-multiply program)
//   align_word()   : clears the byte-offset bits of an address
package pc_seq_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StHalted = 2'd2
  } pc_seq_state_e;

  localparam int unsigned PC_STEP_DEF = 4;
  localparam int unsigned HALT_PC_DEF = 356;

  // Operates on a 64-bit container so any pc width up to 64 can share it.
  function automatic logic [63:0] align_word(input logic [63:0] addr);
    return {addr[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, clears the count
//   inc : count up by one this edge (ignored once saturated)
//   clr : synchronous clear, same effect as rst
//   q   : current count
module sat_counter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] q
);

  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter source for the single-cycle MIPS core.
// Sequences fetch addresses from RESET_PC in PC_STEP increments, honours stalls and
// branch/jump redirects, and stops once HALT_PC has been presented.
//   clk             : clock, rising edge
//   rst             : synchronous active-high reset
//   start           : pulse; idle -> run, or halted -> idle (restart)
//   stall           : hold pc this edge
//   redirect_valid  : load the word-aligned redirect_target instead of incrementing
//   redirect_target : branch/jump destination
//   pc              : current fetch address
//   pc_valid        : pc is a live fetch address
//   halted          : program reached HALT_PC
//   misalign        : sticky, a taken redirect target had nonzero bits[1:0]
//   cycle_count     : saturating count of run edges
//   step_req        : only with PC_SEQ_SINGLE_STEP_EN defined; run edges act only when high
// Build option: define PC_SEQ_SINGLE_STEP_EN to add single-step operation.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned          PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
  parameter logic [PC_WIDTH-1:0]  HALT_PC   = PC_WIDTH'(HALT_PC_DEF),
  parameter logic [PC_WIDTH-1:0]  PC_STEP   = PC_WIDTH'(PC_STEP_DEF),
  parameter int unsigned          CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [PC_WIDTH-1:0]  redirect_target,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 pc_valid,
  output logic                 halted,
  output logic                 misalign,
  output logic [CNT_WIDTH-1:0] cycle_count
`ifdef PC_SEQ_SINGLE_STEP_EN
  ,
  input  logic                 step_req
`endif
);

  pc_seq_state_e       state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic                pc_valid_q;
  logic                halted_q;
  logic                misalign_q;

  // Edges on which a running sequencer is allowed to act.
  logic advance;
`ifdef PC_SEQ_SINGLE_STEP_EN
  assign advance = step_req;
`else
  assign advance = 1'b1;
`endif

  logic [63:0]         aligned_ext;
  logic [PC_WIDTH-1:0] redirect_pc;
  assign aligned_ext = align_word(64'(redirect_target));
  assign redirect_pc = aligned_ext[PC_WIDTH-1:0];

  if (PC_WIDTH < 64) begin : g_unused_hi
    logic unused_aligned_hi;
    assign unused_aligned_hi = ^aligned_ext[63:PC_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StRun;
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b1;
          end
        end
        StRun: begin
          if (advance) begin
            // Halt check outranks stall and redirect: the halt pc is shown exactly once.
            if (pc_q == HALT_PC) begin
              state_q    <= StHalted;
              pc_valid_q <= 1'b0;
              halted_q   <= 1'b1;
            end else if (!stall) begin
              if (redirect_valid) begin
                pc_q <= redirect_pc;
                if (redirect_target[1:0] != 2'b00) begin
                  misalign_q <= 1'b1;
                end
              end else begin
                pc_q <= pc_q + PC_STEP;
              end
            end
          end
        end
        StHalted: begin
          if (start) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic cnt_inc;
  logic cnt_clr;
  assign cnt_inc = (state_q == StRun) && advance;
  assign cnt_clr = (state_q == StHalted) && start;

  sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_cycle_cnt (
    .clk(clk),
    .rst(rst),
    .inc(cnt_inc),
    .clr(cnt_clr),
    .q  (cycle_count)
  );

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign halted   = halted_q;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int unsigned PCW     = 32;
  localparam int unsigned CW      = 7;      // small so saturation is reachable
  localparam int unsigned HALT    = 356;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic            clk;
  logic            rst;
  logic            start;
  logic            stall;
  logic            redirect_valid;
  logic [PCW-1:0]  redirect_target;
  logic [PCW-1:0]  pc;
  logic            pc_valid;
  logic            halted;
  logic            misalign;
  logic [CW-1:0]   cycle_count;
  logic            step_req;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain integers and flags.
  bit          m_running;
  bit          m_halted;
  int unsigned m_pc;
  bit          m_valid;
  bit          m_mis;
  int unsigned m_cnt;

  pc_sequencer #(
    .PC_WIDTH (PCW),
    .RESET_PC ('0),
    .HALT_PC  (PCW'(HALT)),
    .PC_STEP  (PCW'(4)),
    .CNT_WIDTH(CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .pc             (pc),
    .pc_valid       (pc_valid),
    .halted         (halted),
    .misalign       (misalign),
    .cycle_count    (cycle_count)
`ifdef PC_SEQ_SINGLE_STEP_EN
    ,
    .step_req       (step_req)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit st, input bit rv,
                            input int unsigned rt, input bit stp);
    bit act;
`ifdef PC_SEQ_SINGLE_STEP_EN
    act = stp;
`else
    act = 1'b1;
`endif
    if (r) begin
      m_running = 0; m_halted = 0; m_pc = 0; m_valid = 0; m_mis = 0; m_cnt = 0;
    end else if (m_running) begin
      if (act) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (m_pc == HALT) begin
          m_running = 0; m_halted = 1; m_valid = 0;
        end else if (!st) begin
          if (rv) begin
            m_pc = rt - (rt % 4);
            if (rt % 4 != 0) m_mis = 1;
          end else begin
            m_pc = m_pc + 4;   // int unsigned wraps at 2^32 like the pc
          end
        end
      end
    end else if (m_halted) begin
      if (s) begin
        m_halted = 0; m_pc = 0; m_cnt = 0;
      end
    end else if (s) begin
      m_running = 1; m_pc = 0; m_valid = 1;
    end
  endtask

  // Drive one cycle, advance the model at the edge, compare #1 later.
  task automatic cyc(input bit r, input bit s, input bit st, input bit rv,
                     input int unsigned rt, input bit stp);
    rst = r; start = s; stall = st; redirect_valid = rv;
    redirect_target = PCW'(rt); step_req = stp;
    @(posedge clk);
    model_step(r, s, st, rv, rt, stp);
    #1;
    check("pc", 64'(pc), 64'(m_pc));
    check("pc_valid", 64'(pc_valid), 64'(m_valid));
    check("halted", 64'(halted), 64'(m_halted));
    check("misalign", 64'(misalign), 64'(m_mis));
    check("cycle_count", 64'(cycle_count), 64'(m_cnt));
  endtask

  // Free-run (with step_req high) until the model pc reaches target, bounded.
  task automatic run_to(input int unsigned target);
    for (int i = 0; i < 200 && m_pc != target; i++) cyc(0, 0, 0, 0, 0, 1);
    check("run_to_reached", 64'(pc), 64'(target));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_target = '0; step_req = 1'b1;

    // Reset state
    cyc(1, 0, 0, 0, 0, 1);
    check("reset_pc", 64'(pc), 64'd0);
    check("reset_valid", 64'(pc_valid), 64'd0);

    // 1: full program run to halt
    cyc(0, 1, 0, 0, 0, 1);
    check("t1_first_pc", 64'(pc), 64'd0);
    check("t1_first_valid", 64'(pc_valid), 64'd1);
    run_to(HALT);
    check("t1_not_yet_halted", 64'(halted), 64'd0);
    cyc(0, 0, 0, 0, 0, 1);
    check("t1_halted", 64'(halted), 64'd1);
    check("t1_halt_pc", 64'(pc), 64'(HALT));
    check("t1_count", 64'(cycle_count), 64'd90);
    cyc(0, 0, 0, 0, 0, 1);
    check("t1_count_frozen", 64'(cycle_count), 64'd90);
    // restart: halted -> idle
    cyc(0, 1, 0, 0, 0, 1);
    check("t1_restart_cnt", 64'(cycle_count), 64'd0);
    check("t1_restart_pc", 64'(pc), 64'd0);

    // 2: stall for 3 cycles at pc=40
    cyc(0, 1, 0, 0, 0, 1);
    run_to(40);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0, 0, 1);
      check("t2_hold", 64'(pc), 64'd40);
    end
    check("t2_cnt_during_stall", 64'(cycle_count), 64'd13);
    cyc(0, 0, 0, 0, 0, 1);
    check("t2_resume", 64'(pc), 64'd44);

    // 3: misaligned redirect
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 1);
    run_to(20);
    cyc(0, 0, 0, 1, 32'h66, 1);
    check("t3_redirect_pc", 64'(pc), 64'h64);
    check("t3_misalign", 64'(misalign), 64'd1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
    check("t3_misalign_sticky", 64'(misalign), 64'd1);

    // 4: stall beats redirect; redirect onto halt address, then redirect ignored at halt
    cyc(0, 0, 1, 1, 32'h10, 1);
    check("t4_stall_redirect_hold", 64'(pc), 64'h70);
    cyc(0, 0, 0, 1, HALT, 1);
    check("t4_land_halt", 64'(pc), 64'(HALT));
    check("t4_land_not_halted", 64'(halted), 64'd0);
    cyc(0, 0, 0, 1, 32'h10, 1);
    check("t4_halted", 64'(halted), 64'd1);
    check("t4_halt_pc", 64'(pc), 64'(HALT));

    // 5: reset mid-run at pc=200
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 1);
    run_to(200);
    cyc(1, 0, 0, 0, 0, 1);
    check("t5_pc", 64'(pc), 64'd0);
    check("t5_valid", 64'(pc_valid), 64'd0);
    cyc(0, 0, 0, 0, 0, 1);
    check("t5_idle_hold", 64'(pc_valid), 64'd0);
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    check("t5_resumed", 64'(pc), 64'd4);

    // counter saturation: long stall in run
    cyc(0, 1, 1, 0, 0, 1);  // start ignored while running
    for (int i = 0; i < 140; i++) cyc(0, 0, 1, 0, 0, 1);
    check("sat_count", 64'(cycle_count), 64'(CNT_MAX));
    check("sat_pc_held", 64'(pc), 64'd4);

`ifdef PC_SEQ_SINGLE_STEP_EN
    // 6: five step pulses three cycles apart
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    for (int p = 0; p < 5; p++) begin
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
    end
    check("t6_pc", 64'(pc), 64'd20);
    check("t6_count", 64'(cycle_count), 64'd5);
`endif

    // Random phase
    cyc(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      bit r, s, st, rv, stp;
      int unsigned rt;
      r   = ($urandom_range(0, 199) == 0);
      s   = ($urandom_range(0, 9) == 0);
      st  = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 7) == 0);
      stp = ($urandom_range(0, 2) != 0);
      rt  = $urandom_range(0, 95) * 4;
      if ($urandom_range(0, 5) == 0) rt = rt + $urandom_range(1, 3);
      if ($urandom_range(0, 9) == 0) rt = HALT;
      cyc(r, s, st, rv, rt, stp);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
